// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fixup cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  // state | meaning
  // IDLE  | waiting for Start
  // CALC  | one multiply/divide iteration per edge
  // FIX   | apply result signs, write Hi/Lo
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             op_div, neg_q, neg_r;
  logic [WIDTH-1:0] acc, mq, opb;

  logic             launch, div_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_diff, acc_step, mq_step, quo_fix, rem_fix;
  logic             sub_ok;
  logic [2*WIDTH-1:0] prod_fix;

  assign launch   = (state == IDLE) && Start && !Flush;
  assign div_zero = Op[1] && (B == '0);
  assign a_neg    = Op[0] && A[WIDTH-1];
  assign b_neg    = Op[0] && B[WIDTH-1];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;

  assign Busy  = (state != IDLE);
  assign Stall = Busy && (ReadHiLo || Start);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (Start) state_nxt = div_zero ? FIX : CALC;
        CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
        FIX:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Multiply: acc = running high half, mq = multiplier shifting out into low half.
  // Divide:   acc = partial remainder, mq = dividend shifting out / quotient shifting in.
  always_comb begin
    mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
    rem_sh   = {acc, mq[WIDTH-1]};
    sub_ok   = (rem_sh >= {1'b0, opb});
    rem_diff = rem_sh[WIDTH-1:0] - opb;
    if (op_div) begin
      acc_step = sub_ok ? rem_diff : rem_sh[WIDTH-1:0];
      mq_step  = {mq[WIDTH-2:0], sub_ok};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      mq_step  = {mul_sum[0], mq[WIDTH-1:1]};
    end
    prod_fix = neg_q ? -{acc, mq} : {acc, mq};
    quo_fix  = neg_q ? -mq : mq;
    rem_fix  = neg_r ? -acc : acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      opb    <= '0;
      Hi     <= '0;
      Lo     <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= (state == FIX) && !Flush;
      if (launch) begin
        cnt    <= '0;
        op_div <= Op[1];
        if (div_zero) begin
          // Divide by zero bypasses CALC; FIX passes acc/mq straight through.
          acc   <= A;
          mq    <= '1;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          acc   <= '0;
          mq    <= Op[1] ? a_mag : b_mag;
          opb   <= Op[1] ? b_mag : a_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= Op[1] && a_neg;
        end
      end else if (state == CALC && !Flush) begin
        acc <= acc_step;
        mq  <= mq_step;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !Flush) begin
        if (op_div) begin
          Hi <= rem_fix;
          Lo <= quo_fix;
        end else begin
          Hi <= prod_fix[2*WIDTH-1:WIDTH];
          Lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule
